sram_controller: RTL and testbench
==================================

Name: sram_controller

Overview:
Synchronous initiator that drives the asynchronous 2K x 8 SRAM bus (address, data, active-low write strobe, active-low output enable) from a clocked valid/ready request port.
- Generates write strobes with programmable setup/pulse/hold cycles and read accesses with a programmable access time.
- Returns read data on a one-cycle response strobe.
- Sits between the CPU/sequencer logic and the SRAM, one controller per SRAM.

Parameters:
DATA_WIDTH, 8, width of SRAM data bus and request/response data
ADDR_WIDTH, 11, width of SRAM address
RAM_DEPTH, 2048, number of words; used only by the clear sequencer
SETUP_CYCLES, 1, cycles address/data are stable with WE# high before WE# falls (>=1)
PULSE_CYCLES, 2, cycles WE# is held low (>=1)
HOLD_CYCLES, 1, cycles address/data are held after WE# rises (>=1)
READ_CYCLES, 2, cycles OE# is low before read data is sampled (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request this cycle
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  request address
req_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  one-cycle pulse, rsp_rdata is valid
rsp_rdata  out  DATA_WIDTH  read data
sram_address  out  ADDR_WIDTH  SRAM address
sram_data_out  out  DATA_WIDTH  data to SRAM
sram_data_drive  out  1  1 = top level enables tristate driver onto SRAM data bus
sram_data_in  in  DATA_WIDTH  data from SRAM
sram_write_enable  out  1  WE#, active low, SRAM commits on rising edge
sram_output_enable  out  1  OE#, active low

Behaviour:
- Reset values, applied asynchronously:
  - sram_write_enable=1, sram_output_enable=1, sram_data_drive=0
  - sram_address=0, sram_data_out=0, rsp_valid=0, rsp_rdata=0
  - state=IDLE; req_ready=1 (0 while CLEAR runs, see Optional Feature)
- States: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_ACCESS (CLEAR with option).
- Accept: request is taken on a rising edge where req_valid && req_ready. req_ready is 1 only in IDLE, so one request is in flight at most.
- Write request: addr/wdata are registered onto sram_address/sram_data_out; sram_data_drive=1 and OE#=1 throughout.
  - WR_SETUP: SETUP_CYCLES cycles, WE#=1.
  - WR_PULSE: PULSE_CYCLES cycles, WE#=0.
  - WR_HOLD: HOLD_CYCLES cycles, WE#=1; the SRAM commits on the WE# rising edge at entry to WR_HOLD.
  - Then IDLE with sram_data_drive=0. Defaults: accept at edge T, req_ready high again after edge T+4.
- Read request: sram_address registered, OE#=0, WE#=1, sram_data_drive=0.
  - RD_ACCESS lasts READ_CYCLES cycles; on its final edge, sram_data_in is captured into rsp_rdata.
  - Same edge: OE#=1, rsp_valid=1 for exactly one cycle, state=IDLE.
  - Read latency is READ_CYCLES+1 edges from acceptance (default 3).
- Invariants:
  - WE# and OE# are never both 0.
  - sram_data_drive=1 never coincides with OE#=0.
  - Every read-to-write and write-to-read transition passes through at least one IDLE cycle (bus turnaround).
- Outside a read, rsp_rdata holds its last value. sram_address and sram_data_out hold their last value in IDLE.
- req_* inputs are ignored when req_ready=0; there is no queueing.
- Reset mid-write forces WE# high asynchronously. The SRAM may commit the partially set-up word; the content at that address is undefined after such a reset. Reset mid-read drops the response (no rsp_valid).
- Timing counter is ceil(log2(max timing parameter+1)) bits, loads parameter-1 on state entry, and advances the state at 0.

Optional Feature:
Macro SRAM_CTRL_CLEAR_EN.
- Defined: after reset release the controller enters CLEAR and writes 0 to addresses 0..RAM_DEPTH-1 in ascending order, each using the normal setup/pulse/hold sequence. req_ready=0 until the last word's WR_HOLD completes, then IDLE. Reset during CLEAR restarts the clear from address 0.
- Undefined: CLEAR state and address counter are absent, and req_ready=1 from reset.

Decomposition:
- Package sram_ctrl_pkg: state enum (IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_ACCESS, CLEAR); default timing constants; DATA_WIDTH/ADDR_WIDTH defaults.
- One natural sub-module, sram_ctrl_timer: loadable down-counter with a zero flag, instanced once and shared by all states.
- Top level owns the FSM, bus registers and clear address counter.

Test Plan:
- Write 0x5A to 0x123 (defaults) -> WE# low for exactly 2 cycles, preceded by 1 and followed by 1 cycle of stable addr/data; SRAM model mem[0x123]=0x5A; req_ready returns after 4 busy cycles.
- Read 0x123 after that write -> OE# low 2 cycles, rsp_valid one cycle at T+3, rsp_rdata=0x5A; sram_data_drive=0 throughout.
- Back-to-back write 0x7FF=0xA5 then read 0x7FF with req_valid held high -> one IDLE cycle between the transactions, rsp_rdata=0xA5, WE#/OE# never both low (assertion).
- Assert rst_n low in WR_PULSE -> WE#=1, OE#=1, sram_data_drive=0 immediately (same timestep); after release, state is IDLE and no rsp_valid.
- With SRAM_CTRL_CLEAR_EN, preload model with 0xFF, reset -> req_ready low for 2048*4 cycles, then all mem=0x00; a read of 0x000 returns 0x00.
- Sweep SETUP/PULSE/HOLD/READ = 1/1/1/1 and 3/4/2/5 -> measured strobe widths equal the parameters; read latency = READ_CYCLES+1.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the asynchronous SRAM controller.
package sram_ctrl_pkg;

  localparam int unsigned DEF_DATA_WIDTH   = 8;
  localparam int unsigned DEF_ADDR_WIDTH   = 11;
  localparam int unsigned DEF_RAM_DEPTH    = 2048;
  localparam int unsigned DEF_SETUP_CYCLES = 1;
  localparam int unsigned DEF_PULSE_CYCLES = 2;
  localparam int unsigned DEF_HOLD_CYCLES  = 1;
  localparam int unsigned DEF_READ_CYCLES  = 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_SETUP  = 3'd1,
    WR_PULSE  = 3'd2,
    WR_HOLD   = 3'd3,
    RD_ACCESS = 3'd4,
    CLEAR     = 3'd5
  } state_e;

  // Largest of the four timing parameters.
  function automatic int unsigned max_cycles(input int unsigned a, input int unsigned b,
                                             input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Counter width able to hold max_cyc-1 down to 0 with a little headroom.
  function automatic int unsigned timer_width(input int unsigned max_cyc);
    return (max_cyc < 1) ? 1 : $clog2(max_cyc + 1);
  endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// Request/response port between the CPU side and the SRAM controller.
interface sram_ctrl_if
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/sram_ctrl_timer.sv
// Loadable down-counter shared by every timed state of the SRAM controller.
module sram_ctrl_timer #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero_c
);

  logic [WIDTH-1:0] count_q;

  // Load on state entry, otherwise count down and stop at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (count_q != '0) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign zero_c = (count_q == '0);

endmodule

// File: rtl/sram_controller.sv
// Clocked valid/ready front end driving an asynchronous SRAM (WE#/OE# strobes).
// Optional power-on clear of the whole array: define SRAM_CTRL_CLEAR_EN.
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned RAM_DEPTH    = DEF_RAM_DEPTH,
  parameter int unsigned SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int unsigned PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter int unsigned HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int unsigned READ_CYCLES  = DEF_READ_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_ctrl_if.slave            bus,
  output logic [ADDR_WIDTH-1:0] sram_address,
  output logic [DATA_WIDTH-1:0] sram_data_out,
  output logic                  sram_data_drive,
  input  logic [DATA_WIDTH-1:0] sram_data_in,
  output logic                  sram_write_enable,
  output logic                  sram_output_enable
);

  localparam int unsigned TMR_W =
    timer_width(max_cycles(SETUP_CYCLES, PULSE_CYCLES, HOLD_CYCLES, READ_CYCLES));

  localparam logic [TMR_W-1:0] SETUP_LOAD = TMR_W'(SETUP_CYCLES - 1);
  localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LOAD  = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] READ_LOAD  = TMR_W'(READ_CYCLES - 1);

`ifdef SRAM_CTRL_CLEAR_EN
  localparam state_e RESET_STATE = CLEAR;
  localparam logic   RESET_READY = 1'b0;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
`else
  localparam state_e RESET_STATE = IDLE;
  localparam logic   RESET_READY = 1'b1;
`endif

  // Reject parameter sets the strobe sequencing cannot honour.
  if (SETUP_CYCLES < 1 || PULSE_CYCLES < 1 || HOLD_CYCLES < 1 || READ_CYCLES < 1 ||
      RAM_DEPTH < 1 || RAM_DEPTH > (32'd1 << ADDR_WIDTH)) begin : g_param_check
    $error("sram_controller: timing parameters must be >= 1 and RAM_DEPTH must fit ADDR_WIDTH");
  end

  state_e                state_q, state_d;
  logic                  we_n_q, we_n_d;
  logic                  oe_n_q, oe_n_d;
  logic                  drive_q, drive_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  req_ready_q, req_ready_d;
  logic                  tmr_load;
  logic [TMR_W-1:0]      tmr_value;
  logic                  tmr_zero;

`ifdef SRAM_CTRL_CLEAR_EN
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  clearing_q, clearing_d;
`endif

  sram_ctrl_timer #(
    .WIDTH(TMR_W)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (tmr_load),
    .load_value(tmr_value),
    .zero_c    (tmr_zero)
  );

  // State and bus registers; reset parks both strobes high and releases the data bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_STATE;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      drive_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      req_ready_q <= RESET_READY;
    end else begin
      state_q     <= state_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      drive_q     <= drive_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      req_ready_q <= req_ready_d;
    end
  end

`ifdef SRAM_CTRL_CLEAR_EN
  // Clear sequencer: restarts from address 0 on every reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_addr_q <= '0;
      clearing_q <= 1'b1;
    end else begin
      clr_addr_q <= clr_addr_d;
      clearing_q <= clearing_d;
    end
  end
`endif

  // Next state, next bus values and timer loads.
  always_comb begin
    state_d     = state_q;
    we_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    drive_d     = drive_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    tmr_load    = 1'b0;
    tmr_value   = '0;
`ifdef SRAM_CTRL_CLEAR_EN
    clr_addr_d  = clr_addr_q;
    clearing_d  = clearing_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          addr_d   = ADDR_WIDTH'(bus.req_addr);
          tmr_load = 1'b1;
          if (bus.req_write) begin
            wdata_d   = DATA_WIDTH'(bus.req_wdata);
            drive_d   = 1'b1;
            state_d   = WR_SETUP;
            tmr_value = SETUP_LOAD;
          end else begin
            drive_d   = 1'b0;
            oe_n_d    = 1'b0;
            state_d   = RD_ACCESS;
            tmr_value = READ_LOAD;
          end
        end
      end

      WR_SETUP: begin
        if (tmr_zero) begin
          we_n_d    = 1'b0;
          state_d   = WR_PULSE;
          tmr_load  = 1'b1;
          tmr_value = PULSE_LOAD;
        end
      end

      WR_PULSE: begin
        // The SRAM commits on the WE# rising edge that enters WR_HOLD.
        we_n_d = 1'b0;
        if (tmr_zero) begin
          we_n_d    = 1'b1;
          state_d   = WR_HOLD;
          tmr_load  = 1'b1;
          tmr_value = HOLD_LOAD;
        end
      end

      WR_HOLD: begin
        if (tmr_zero) begin
          state_d = IDLE;
          drive_d = 1'b0;
`ifdef SRAM_CTRL_CLEAR_EN
          if (clearing_q) begin
            if (clr_addr_q == LAST_ADDR) begin
              clearing_d = 1'b0;
            end else begin
              clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
              addr_d     = clr_addr_q + ADDR_WIDTH'(1);
              wdata_d    = '0;
              drive_d    = 1'b1;
              state_d    = WR_SETUP;
              tmr_load   = 1'b1;
              tmr_value  = SETUP_LOAD;
            end
          end
`endif
        end
      end

      RD_ACCESS: begin
        oe_n_d = 1'b0;
        if (tmr_zero) begin
          oe_n_d      = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = sram_data_in;
          state_d     = IDLE;
        end
      end

`ifdef SRAM_CTRL_CLEAR_EN
      CLEAR: begin
        addr_d    = clr_addr_q;
        wdata_d   = '0;
        drive_d   = 1'b1;
        state_d   = WR_SETUP;
        tmr_load  = 1'b1;
        tmr_value = SETUP_LOAD;
      end
`endif

      default: begin
        state_d = IDLE;
        drive_d = 1'b0;
      end
    endcase

    req_ready_d = (state_d == IDLE);
  end

  assign sram_address       = addr_q;
  assign sram_data_out      = wdata_q;
  assign sram_data_drive    = drive_q;
  assign sram_write_enable  = we_n_q;
  assign sram_output_enable = oe_n_q;
  assign bus.req_ready      = req_ready_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_rdata      = rsp_rdata_q;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: default timing plus fast (1/1/1/1) and slow (3/4/2/5) instances.
module tb_sram_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  sel;
  logic        req_valid;
  logic        req_write;
  logic [10:0] req_addr;
  logic [7:0]  req_wdata;

  int n_pass  = 0;
  int n_total = 0;
  int inv_err = 0;
  int rsp0_cnt = 0;

  sram_ctrl_if bus0 ();
  sram_ctrl_if bus1 ();
  sram_ctrl_if bus2 ();

  assign bus0.req_valid = req_valid & (sel == 2'd0);
  assign bus1.req_valid = req_valid & (sel == 2'd1);
  assign bus2.req_valid = req_valid & (sel == 2'd2);
  assign bus0.req_write = req_write;
  assign bus1.req_write = req_write;
  assign bus2.req_write = req_write;
  assign bus0.req_addr  = req_addr;
  assign bus1.req_addr  = req_addr;
  assign bus2.req_addr  = req_addr;
  assign bus0.req_wdata = req_wdata;
  assign bus1.req_wdata = req_wdata;
  assign bus2.req_wdata = req_wdata;

  logic        we_n   [3];
  logic        oe_n   [3];
  logic        drv    [3];
  logic [10:0] s_addr [3];
  logic [7:0]  s_dout [3];
  logic [7:0]  s_din  [3];

  sram_controller u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus0),
    .sram_address(s_addr[0]), .sram_data_out(s_dout[0]), .sram_data_drive(drv[0]),
    .sram_data_in(s_din[0]), .sram_write_enable(we_n[0]), .sram_output_enable(oe_n[0])
  );

  sram_controller #(
    .RAM_DEPTH(16), .SETUP_CYCLES(1), .PULSE_CYCLES(1), .HOLD_CYCLES(1), .READ_CYCLES(1)
  ) u_fast (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .sram_address(s_addr[1]), .sram_data_out(s_dout[1]), .sram_data_drive(drv[1]),
    .sram_data_in(s_din[1]), .sram_write_enable(we_n[1]), .sram_output_enable(oe_n[1])
  );

  sram_controller #(
    .RAM_DEPTH(16), .SETUP_CYCLES(3), .PULSE_CYCLES(4), .HOLD_CYCLES(2), .READ_CYCLES(5)
  ) u_slow (
    .clk(clk), .rst_n(rst_n), .bus(bus2),
    .sram_address(s_addr[2]), .sram_data_out(s_dout[2]), .sram_data_drive(drv[2]),
    .sram_data_in(s_din[2]), .sram_write_enable(we_n[2]), .sram_output_enable(oe_n[2])
  );

  // Behavioural SRAMs: commit on WE# rising edge, drive data while OE# is low.
  logic [7:0] mem0 [2048];
  logic [7:0] mem1 [2048];
  logic [7:0] mem2 [2048];

  always @(posedge we_n[0]) if (drv[0] === 1'b1) mem0[s_addr[0]] <= s_dout[0];
  always @(posedge we_n[1]) if (drv[1] === 1'b1) mem1[s_addr[1]] <= s_dout[1];
  always @(posedge we_n[2]) if (drv[2] === 1'b1) mem2[s_addr[2]] <= s_dout[2];

  assign s_din[0] = (oe_n[0] === 1'b0) ? mem0[s_addr[0]] : 8'h00;
  assign s_din[1] = (oe_n[1] === 1'b0) ? mem1[s_addr[1]] : 8'h00;
  assign s_din[2] = (oe_n[2] === 1'b0) ? mem2[s_addr[2]] : 8'h00;

  function automatic logic [7:0] mem_rd(input logic [1:0] s, input logic [10:0] a);
    case (s)
      2'd1:    return mem1[a];
      2'd2:    return mem2[a];
      default: return mem0[a];
    endcase
  endfunction

  // View of the instance currently under test.
  logic        o_rdy, o_rv, o_we, o_oe, o_drv;
  logic [7:0]  o_rd, o_dout;
  logic [10:0] o_addr;
  always_comb begin
    case (sel)
      2'd1: begin
        o_rdy = bus1.req_ready; o_rv = bus1.rsp_valid; o_rd = bus1.rsp_rdata;
        o_we = we_n[1]; o_oe = oe_n[1]; o_drv = drv[1]; o_addr = s_addr[1]; o_dout = s_dout[1];
      end
      2'd2: begin
        o_rdy = bus2.req_ready; o_rv = bus2.rsp_valid; o_rd = bus2.rsp_rdata;
        o_we = we_n[2]; o_oe = oe_n[2]; o_drv = drv[2]; o_addr = s_addr[2]; o_dout = s_dout[2];
      end
      default: begin
        o_rdy = bus0.req_ready; o_rv = bus0.rsp_valid; o_rd = bus0.rsp_rdata;
        o_we = we_n[0]; o_oe = oe_n[0]; o_drv = drv[0]; o_addr = s_addr[0]; o_dout = s_dout[0];
      end
    endcase
  end

  // Bus invariants on every instance, tallied for one check at the end.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int i = 0; i < 3; i++) begin
        if ((we_n[i] === 1'b0 && oe_n[i] === 1'b0) || (drv[i] === 1'b1 && oe_n[i] === 1'b0))
          inv_err++;
      end
    end
    if (bus0.rsp_valid === 1'b1) rsp0_cnt++;
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic wait_ready(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_rdy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send(input logic w, input logic [10:0] a, input logic [7:0] d);
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Negedge index k reflects the state after acceptance edge T+k.
  task automatic measure_write(output int su, output int pu, output int ho,
                               output int busy, output int bad);
    bit seen_low;
    su = 0; pu = 0; ho = 0; busy = 0; bad = 0; seen_low = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (o_rdy === 1'b1) break;
      busy++;
      if (o_we === 1'b0) begin
        pu++;
        seen_low = 1'b1;
      end else if (seen_low) ho++;
      else su++;
      if (o_drv !== 1'b1 || o_oe !== 1'b1 || o_addr !== req_addr || o_dout !== req_wdata) bad++;
    end
  endtask

  task automatic measure_read(output int oe_cnt, output int lat, output logic [7:0] rdata,
                              output int bad);
    oe_cnt = 0; lat = -1; rdata = 8'h00; bad = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (o_rv === 1'b1) begin
        lat = k;
        rdata = o_rd;
        if (o_oe !== 1'b1) bad++;
        break;
      end
      if (o_oe === 1'b0) oe_cnt++;
      if (o_drv !== 1'b0 || o_we !== 1'b1) bad++;
    end
  endtask

  task automatic test_reset;
    bit ok;
    sel = 2'd0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rst_n = 1'b0;
    #12;
    n_total++; if (o_we !== 1'b1) $display("FAIL reset_we: got %b want 1", o_we); else n_pass++;
    n_total++; if (o_oe !== 1'b1) $display("FAIL reset_oe: got %b want 1", o_oe); else n_pass++;
    n_total++; if (o_drv !== 1'b0) $display("FAIL reset_drive: got %b want 0", o_drv); else n_pass++;
    n_total++; if (o_addr !== 11'h000) $display("FAIL reset_addr: got %h want 000", o_addr); else n_pass++;
    n_total++; if (o_dout !== 8'h00) $display("FAIL reset_dout: got %h want 00", o_dout); else n_pass++;
    n_total++; if (o_rv !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", o_rv); else n_pass++;
    n_total++; if (o_rd !== 8'h00) $display("FAIL reset_rsp_rdata: got %h want 00", o_rd); else n_pass++;
`ifdef SRAM_CTRL_CLEAR_EN
    n_total++; if (o_rdy !== 1'b0) $display("FAIL reset_ready: got %b want 0", o_rdy); else n_pass++;
`else
    n_total++; if (o_rdy !== 1'b1) $display("FAIL reset_ready: got %b want 1", o_rdy); else n_pass++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(9000, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL reset_ready_after_release: got %b want 1", ok); else n_pass++;
  endtask

  task automatic test_write;
    int su, pu, ho, busy, bad;
    bit ok;
    sel = 2'd0;
    wait_ready(100, ok);
    send(1'b1, 11'h123, 8'h5A);
    measure_write(su, pu, ho, busy, bad);
    n_total++; if (su !== 1) $display("FAIL wr_setup: got %0d want 1", su); else n_pass++;
    n_total++; if (pu !== 2) $display("FAIL wr_pulse: got %0d want 2", pu); else n_pass++;
    n_total++; if (ho !== 1) $display("FAIL wr_hold: got %0d want 1", ho); else n_pass++;
    n_total++; if (busy !== 4) $display("FAIL wr_busy: got %0d want 4", busy); else n_pass++;
    n_total++; if (bad !== 0) $display("FAIL wr_bus_stable: got %0d bad cycles want 0", bad); else n_pass++;
    n_total++; if (o_drv !== 1'b0) $display("FAIL wr_drive_release: got %b want 0", o_drv); else n_pass++;
    n_total++; if (mem0[11'h123] !== 8'h5A) $display("FAIL wr_mem: got %h want 5a", mem0[11'h123]); else n_pass++;
  endtask

  task automatic test_read;
    int oe_cnt, lat, bad;
    logic [7:0] rdata;
    bit ok;
    sel = 2'd0;
    wait_ready(100, ok);
    send(1'b0, 11'h123, 8'h00);
    measure_read(oe_cnt, lat, rdata, bad);
    n_total++; if (oe_cnt !== 2) $display("FAIL rd_oe_width: got %0d want 2", oe_cnt); else n_pass++;
    // Pulse set by edge T+2, so a consumer registers it at edge T+3.
    n_total++; if (lat !== 2) $display("FAIL rd_latency: got %0d want 2", lat); else n_pass++;
    n_total++; if (rdata !== 8'h5A) $display("FAIL rd_data: got %h want 5a", rdata); else n_pass++;
    n_total++; if (bad !== 0) $display("FAIL rd_strobes: got %0d bad cycles want 0", bad); else n_pass++;
    @(negedge clk);
    n_total++; if (o_rv !== 1'b0) $display("FAIL rd_pulse_width: got %b want 0", o_rv); else n_pass++;
    n_total++; if (o_rd !== 8'h5A) $display("FAIL rd_data_hold: got %h want 5a", o_rd); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int idle_at, rd_at, rv_at;
    logic [7:0] rdata;
    bit ok;
    sel = 2'd0;
    idle_at = -1; rd_at = -1; rv_at = -1; rdata = 8'h00;
    wait_ready(100, ok);
    req_write = 1'b1; req_addr = 11'h7FF; req_wdata = 8'hA5; req_valid = 1'b1;
    @(posedge clk);
    #1 req_write = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (idle_at < 0 && o_rdy === 1'b1) idle_at = k;
      else if (idle_at >= 0 && rd_at < 0 && o_rdy === 1'b0) begin
        rd_at = k;
        req_valid = 1'b0;
      end
      if (o_rv === 1'b1) begin
        rv_at = k;
        rdata = o_rd;
        break;
      end
    end
    req_valid = 1'b0;
    n_total++; if (idle_at !== 4) $display("FAIL b2b_idle_at: got %0d want 4", idle_at); else n_pass++;
    n_total++; if (rd_at !== 5) $display("FAIL b2b_read_start: got %0d want 5", rd_at); else n_pass++;
    n_total++; if (rv_at !== 7) $display("FAIL b2b_rsp_at: got %0d want 7", rv_at); else n_pass++;
    n_total++; if (rdata !== 8'hA5) $display("FAIL b2b_rdata: got %h want a5", rdata); else n_pass++;
    n_total++; if (mem0[11'h7FF] !== 8'hA5) $display("FAIL b2b_mem: got %h want a5", mem0[11'h7FF]); else n_pass++;
  endtask

  task automatic test_sweep;
    int su, pu, ho, busy, bad, oe_cnt, lat;
    logic [7:0] rdata;
    bit ok;
    // Fast instance, all timings 1.
    sel = 2'd1;
    wait_ready(1000, ok);
    send(1'b1, 11'h00A, 8'h3C);
    measure_write(su, pu, ho, busy, bad);
    n_total++; if (su !== 1 || pu !== 1 || ho !== 1) $display("FAIL fast_wr_widths: got %0d/%0d/%0d want 1/1/1", su, pu, ho); else n_pass++;
    n_total++; if (busy !== 3 || bad !== 0) $display("FAIL fast_wr_busy: got %0d busy %0d bad want 3 busy 0 bad", busy, bad); else n_pass++;
    n_total++; if (mem_rd(sel, 11'h00A) !== 8'h3C) $display("FAIL fast_wr_mem: got %h want 3c", mem_rd(sel, 11'h00A)); else n_pass++;
    wait_ready(100, ok);
    send(1'b0, 11'h00A, 8'h00);
    measure_read(oe_cnt, lat, rdata, bad);
    n_total++; if (oe_cnt !== 1 || lat !== 1) $display("FAIL fast_rd_timing: got oe %0d lat %0d want oe 1 lat 1", oe_cnt, lat); else n_pass++;
    n_total++; if (rdata !== 8'h3C || bad !== 0) $display("FAIL fast_rd_data: got %h bad %0d want 3c bad 0", rdata, bad); else n_pass++;
    // Slow instance, 3/4/2 write and 5-cycle read.
    sel = 2'd2;
    wait_ready(1000, ok);
    send(1'b1, 11'h456, 8'hC3);
    measure_write(su, pu, ho, busy, bad);
    n_total++; if (su !== 3 || pu !== 4 || ho !== 2) $display("FAIL slow_wr_widths: got %0d/%0d/%0d want 3/4/2", su, pu, ho); else n_pass++;
    n_total++; if (busy !== 9 || bad !== 0) $display("FAIL slow_wr_busy: got %0d busy %0d bad want 9 busy 0 bad", busy, bad); else n_pass++;
    n_total++; if (mem_rd(sel, 11'h456) !== 8'hC3) $display("FAIL slow_wr_mem: got %h want c3", mem_rd(sel, 11'h456)); else n_pass++;
    wait_ready(100, ok);
    send(1'b0, 11'h456, 8'h00);
    measure_read(oe_cnt, lat, rdata, bad);
    n_total++; if (oe_cnt !== 5 || lat !== 5) $display("FAIL slow_rd_timing: got oe %0d lat %0d want oe 5 lat 5", oe_cnt, lat); else n_pass++;
    n_total++; if (rdata !== 8'hC3 || bad !== 0) $display("FAIL slow_rd_data: got %h bad %0d want c3 bad 0", rdata, bad); else n_pass++;
    sel = 2'd0;
  endtask

  task automatic test_reset_mid_write;
    bit ok, found;
    int rsp_before;
    sel = 2'd0;
    found = 1'b0;
    wait_ready(100, ok);
    send(1'b1, 11'h055, 8'h33);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (o_we === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    n_total++; if (found !== 1'b1) $display("FAIL rstw_pulse_seen: got %b want 1", found); else n_pass++;
    rsp_before = rsp0_cnt;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (o_we !== 1'b1) $display("FAIL rstw_we: got %b want 1", o_we); else n_pass++;
    n_total++; if (o_oe !== 1'b1) $display("FAIL rstw_oe: got %b want 1", o_oe); else n_pass++;
    n_total++; if (o_drv !== 1'b0) $display("FAIL rstw_drive: got %b want 0", o_drv); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(9000, ok);
    repeat (3) @(negedge clk);
    n_total++; if (ok !== 1'b1 || o_rdy !== 1'b1) $display("FAIL rstw_idle: got ready %b want 1", o_rdy); else n_pass++;
    n_total++; if (rsp0_cnt !== rsp_before) $display("FAIL rstw_no_rsp: got %0d pulses want 0", rsp0_cnt - rsp_before); else n_pass++;
  endtask

  task automatic test_reset_mid_read;
    bit ok, found;
    int rsp_before;
    sel = 2'd0;
    found = 1'b0;
    wait_ready(100, ok);
    send(1'b0, 11'h123, 8'h00);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (o_oe === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    n_total++; if (found !== 1'b1) $display("FAIL rstr_oe_seen: got %b want 1", found); else n_pass++;
    rsp_before = rsp0_cnt;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (o_oe !== 1'b1) $display("FAIL rstr_oe: got %b want 1", o_oe); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(9000, ok);
    repeat (3) @(negedge clk);
    n_total++; if (ok !== 1'b1 || o_rdy !== 1'b1) $display("FAIL rstr_idle: got ready %b want 1", o_rdy); else n_pass++;
    n_total++; if (rsp0_cnt !== rsp_before) $display("FAIL rstr_no_rsp: got %0d pulses want 0", rsp0_cnt - rsp_before); else n_pass++;
  endtask

`ifdef SRAM_CTRL_CLEAR_EN
  task automatic test_clear;
    int busy, nonzero, oe_cnt, lat, bad;
    logic [7:0] rdata;
    bit ok;
    sel = 2'd0;
    busy = 0; nonzero = 0;
    @(negedge clk);
    for (int a = 0; a < 2048; a++) mem0[a] = 8'hFF;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 9000; k++) begin
      @(negedge clk);
      if (o_rdy === 1'b1) break;
      busy++;
    end
    n_total++; if (busy !== 2048 * 4) $display("FAIL clear_busy: got %0d want %0d", busy, 2048 * 4); else n_pass++;
    for (int a = 0; a < 2048; a++) if (mem0[a] !== 8'h00) nonzero++;
    n_total++; if (nonzero !== 0) $display("FAIL clear_mem: got %0d nonzero words want 0", nonzero); else n_pass++;
    wait_ready(100, ok);
    send(1'b0, 11'h000, 8'h00);
    measure_read(oe_cnt, lat, rdata, bad);
    n_total++; if (rdata !== 8'h00 || lat !== 2) $display("FAIL clear_read0: got %h lat %0d want 00 lat 2", rdata, lat); else n_pass++;
  endtask
`endif

  task automatic test_invariants;
    n_total++; if (inv_err !== 0) $display("FAIL bus_invariants: got %0d violating cycles want 0", inv_err); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_sweep();
    test_reset_mid_write();
    test_reset_mid_read();
`ifdef SRAM_CTRL_CLEAR_EN
    test_clear();
`endif
    test_invariants();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
